// File: rtl/spi_ctrl_if.sv
// rtl/spi_ctrl_if.sv - host register bus between gpmc_sync and spi_ctrl
// Ports (signals):
//   cs, we, oe : active-low chip select, write enable, output enable
//   address    : register address
//   data_in    : host write data
//   data_out   : registered host read data
// Modports: master = bus driver (gpmc_sync side), slave = spi_ctrl side.
interface spi_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (output cs, we, oe, address, data_in, input data_out);
  modport slave  (input cs, we, oe, address, data_in, output data_out);
endinterface

// File: rtl/spi_ctrl.sv
// rtl/spi_ctrl.sv - register-mapped sequencer feeding an spi master from a TX FIFO
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   bus             : host register bus (spi_ctrl_if.slave)
//   spi_rst         : active-high reset to the spi master
//   spi_clk_div     : clock divider for the spi master
//   spi_start       : one-cycle transfer start
//   spi_tx          : byte being transmitted
//   spi_rx          : received byte, valid with spi_new_data
//   spi_busy        : spi master transferring
//   spi_new_data    : one-cycle transfer-complete pulse
//   irq             : rx interrupt, active-high
// Registers: 0 setup, 2 state, 4 transmit, 6 receive.
module spi_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_ctrl_if.slave   bus,
  output logic        spi_rst,
  output logic [4:0]  spi_clk_div,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  output logic        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SETUP = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATE = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TX    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RX    = ADDR_WIDTH'(6);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_next;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic       wr_cond, rd_cond, wr_prev, rd_prev, wr_fire, rd_fire;
  logic       sel_setup, sel_state, sel_tx, sel_rx;
  logic [4:0] clk_div;
  logic       send_en, irq_en;
  logic       rx_valid, rx_overrun, tx_overflow;
  logic [7:0] rx_byte;
  logic       soft_rst, tx_full, tx_empty, pop, push_req, push, ovf_set;
  logic       capture, rx_read, clr_w;
  logic [DATA_WIDTH-1:0] rd_data;

  // A held strobe acts once: only the cycle the condition first appears fires.
  assign wr_cond = !bus.cs && !bus.we && bus.oe;
  assign rd_cond = !bus.cs && bus.we && !bus.oe;
  assign wr_fire = wr_cond && !wr_prev;
  assign rd_fire = rd_cond && !rd_prev;

  assign sel_setup = (bus.address == ADDR_SETUP);
  assign sel_state = (bus.address == ADDR_STATE);
  assign sel_tx    = (bus.address == ADDR_TX);
  assign sel_rx    = (bus.address == ADDR_RX);

  assign soft_rst = wr_fire && sel_setup && bus.data_in[0];
  assign tx_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign tx_empty = (count == '0);
  assign pop      = (state == LOAD);
  assign push_req = wr_fire && sel_tx;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!tx_full || pop);
  assign ovf_set  = push_req && tx_full && !pop;
  assign capture  = (state == WAIT_DONE) && spi_new_data;
  assign rx_read  = rd_fire && sel_rx;
  assign clr_w    = wr_fire && sel_state;

  assign spi_clk_div = clk_div;
  assign irq         = irq_en && rx_valid;

  always_comb begin
    rd_data = '0;
    if (sel_setup)      rd_data[7:1] = {irq_en, send_en, clk_div};
    else if (sel_state) rd_data[5:0] = {tx_overflow, rx_overrun, tx_empty, tx_full,
                                        rx_valid, (state != IDLE)};
    else if (sel_rx)    rd_data[7:0] = rx_byte;
  end

  always_comb begin
    state_next = state;
    spi_start  = 1'b0;
    case (state)
      IDLE:      if (send_en && !tx_empty) state_next = LOAD;
      LOAD:      state_next = START;
      START: begin
        spi_start  = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (spi_new_data)  state_next = IDLE;
        else if (spi_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: if (spi_new_data) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (soft_rst) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Storage array carries no reset; count and pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_prev      <= 1'b0;
      rd_prev      <= 1'b0;
      spi_rst      <= 1'b1;
      clk_div      <= '0;
      send_en      <= 1'b0;
      irq_en       <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      spi_tx       <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_overflow  <= 1'b0;
      bus.data_out <= '0;
    end else begin
      wr_prev <= wr_cond;
      rd_prev <= rd_cond;
      spi_rst <= soft_rst;
      if (wr_fire && sel_setup) {irq_en, send_en, clk_div} <= bus.data_in[7:1];
      if (capture) rx_byte <= spi_rx;
      if (rd_fire) bus.data_out <= rd_data;

      if (soft_rst) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        count       <= '0;
        rx_valid    <= 1'b0;
        rx_overrun  <= 1'b0;
        tx_overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          spi_tx <= fifo_mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;

        // New data beats a concurrent read; set beats write-1-clear.
        if (capture)      rx_valid <= 1'b1;
        else if (rx_read) rx_valid <= 1'b0;
        if (capture && rx_valid && !rx_read)  rx_overrun <= 1'b1;
        else if (clr_w && bus.data_in[4])     rx_overrun <= 1'b0;
        if (ovf_set)                          tx_overflow <= 1'b1;
        else if (clr_w && bus.data_in[5])     tx_overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_ctrl.sv
// tb/tb_spi_ctrl.sv - scoreboard testbench for spi_ctrl with a behavioural spi master
module tb_spi_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_rst;
  logic [4:0] spi_clk_div;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx = 8'h00;
  logic       spi_busy = 1'b0;
  logic       spi_new_data = 1'b0;
  logic       irq;

  always #5 clk = ~clk;

  spi_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

  spi_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .spi_rst(spi_rst), .spi_clk_div(spi_clk_div), .spi_start(spi_start),
    .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .irq(irq)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int start_cyc = 0;
  int nd_cyc = 0;
  int nd1 = 0;
  logic [15:0] exp_rd [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  replies [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares spi_tx on every start and data_out after every first read cycle.
  initial begin : monitor
    logic fire, prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      fire = (!bus.cs && bus.we && !bus.oe) && !prev && rst_n;
      prev = !bus.cs && bus.we && !bus.oe;
      @(negedge clk);
      if (spi_start) begin
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start: spi_tx=0x%0h, no byte expected", spi_tx);
        end else check("spi_tx", 32'(spi_tx), 32'(exp_tx.pop_front()));
      end
      if (fire) begin
        if (exp_rd.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: data_out=0x%0h, no read expected", bus.data_out);
        end else check("data_out", 32'(bus.data_out), 32'(exp_rd.pop_front()));
      end
    end
  end

  // Behavioural spi master: busy for 10 cycles after start, then returns the next reply.
  initial begin : spi_model
    forever begin
      @(negedge clk);
      if (spi_start) begin
        start_cyc = cyc;
        spi_busy  = 1'b1;
        repeat (10) @(negedge clk);
        spi_busy     = 1'b0;
        spi_rx       = (replies.size() > 0) ? replies.pop_front() : 8'h00;
        spi_new_data = 1'b1;
        nd_cyc       = cyc;
        @(negedge clk);
        spi_new_data = 1'b0;
        xfer_cnt++;
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input int hold = 1);
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1; bus.address = a; bus.data_in = d;
    repeat (hold) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [15:0] e);
    exp_rd.push_back(e);
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b1; bus.oe = 1'b0; bus.address = a;
    @(negedge clk);
    bus.cs = 1'b1; bus.oe = 1'b1;
  endtask

  task automatic wait_xfer(input int target);
    int t = 0;
    while (xfer_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("xfer_done_in_time", 32'(xfer_cnt >= target), 32'd1);
    @(negedge clk);
  endtask

  initial begin : main
    int t;
    bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b1; bus.address = '0; bus.data_in = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("spi_rst_in_reset", 32'(spi_rst), 32'd1);
    check("data_out_reset", 32'(bus.data_out), 32'd0);
    check("clk_div_reset", 32'(spi_clk_div), 32'd0);
    check("spi_tx_reset", 32'(spi_tx), 32'd0);
    check("irq_reset", 32'(irq), 32'd0);
    check("start_reset", 32'(spi_start), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("spi_rst_release", 32'(spi_rst), 32'd0);
    bus_read(4'h2, 16'h0008);

    // Single byte
    bus_write(4'h0, 16'h004A);
    check("clk_div", 32'(spi_clk_div), 32'd5);
    exp_tx.push_back(8'hA5);
    replies.push_back(8'h3C);
    bus_write(4'h4, 16'h00A5);
    check("start_idle", 32'(spi_start), 32'd0);
    @(negedge clk);
    check("start_load", 32'(spi_start), 32'd0);
    @(negedge clk);
    check("start_latency", 32'(spi_start), 32'd1);
    wait_xfer(1);
    bus_read(4'h2, 16'h000A);
    bus_read(4'h6, 16'h003C);
    bus_read(4'h2, 16'h0008);

    // FIFO full and overflow
    bus_write(4'h0, 16'h000A);
    for (int i = 1; i <= 5; i++) bus_write(4'h4, 16'(i));
    bus_read(4'h2, 16'h0024);
    for (int i = 1; i <= 4; i++) begin
      exp_tx.push_back(8'(i));
      replies.push_back(8'(8'h10 + i));
    end
    bus_write(4'h0, 16'h004A);
    wait_xfer(5);
    bus_read(4'h2, 16'h003A);
    bus_read(4'h6, 16'h0014);
    bus_write(4'h2, 16'h0030);
    bus_read(4'h2, 16'h0008);

    // Overrun, irq and back-to-back spacing
    bus_write(4'h0, 16'h00CA);
    check("irq_idle", 32'(irq), 32'd0);
    exp_tx.push_back(8'h55); exp_tx.push_back(8'h66);
    replies.push_back(8'h77); replies.push_back(8'h88);
    bus_write(4'h4, 16'h0055);
    bus_write(4'h4, 16'h0066);
    wait_xfer(6);
    check("irq_rise", 32'(irq), 32'd1);
    nd1 = nd_cyc;
    wait_xfer(7);
    check("btb_gap", 32'(start_cyc - nd1), 32'd3);
    bus_read(4'h2, 16'h001A);
    bus_read(4'h6, 16'h0088);
    check("irq_clear", 32'(irq), 32'd0);
    bus_write(4'h2, 16'h0010);
    bus_read(4'h2, 16'h0008);

    // Held strobe pushes once
    bus_write(4'h0, 16'h000A);
    bus_write(4'h4, 16'h0099, 6);
    bus_read(4'h2, 16'h0000);

    // Soft reset during WAIT_DONE with two bytes still queued
    bus_write(4'h4, 16'h00AB);
    bus_write(4'h4, 16'h00CD);
    exp_tx.push_back(8'h99);
    replies.push_back(8'h42);
    bus_write(4'h0, 16'h004A);
    t = 0;
    while (!spi_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("busy_seen", 32'(spi_busy), 32'd1);
    repeat (3) @(negedge clk);
    bus_write(4'h0, 16'h004B);
    check("spi_rst_pulse", 32'(spi_rst), 32'd1);
    @(negedge clk);
    check("spi_rst_end", 32'(spi_rst), 32'd0);
    check("clk_div_kept", 32'(spi_clk_div), 32'd5);
    bus_read(4'h2, 16'h0008);
    repeat (30) @(negedge clk);
    bus_read(4'h2, 16'h0008);
    @(negedge clk);
    check("tx_all_seen", 32'(exp_tx.size()), 32'd0);
    check("reads_all_seen", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_ctrl.md
# spi_ctrl

Register-mapped sequencer between the gpmc_sync bus slave and the spi master core. It decodes host accesses to four registers: setup, state, transmit and receive. It buffers transmit bytes in a small FIFO and feeds them one at a time to the spi master through its start/busy/new_data handshake. It also captures received bytes and exposes status and interrupt flags to the host.

## Interface
- ADDR_WIDTH, 4, width of bus address from gpmc_sync
- DATA_WIDTH, 16, bus data width
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- cs  in  1  bus chip select, active-low
- we  in  1  bus write enable, active-low
- oe  in  1  bus output enable, active-low
- address  in  ADDR_WIDTH  register address
- data_in  in  DATA_WIDTH  host write data
- data_out  out  DATA_WIDTH  host read data, registered
- spi_rst  out  1  reset to spi master, active-high
- spi_clk_div  out  5  clock divider to spi master
- spi_start  out  1  one-cycle transfer start pulse
- spi_tx  out  8  byte to transmit, stable from start until done
- spi_rx  in  8  received byte, valid with spi_new_data
- spi_busy  in  1  spi master transferring
- spi_new_data  in  1  one-cycle pulse, transfer complete
- irq  out  1  interrupt, active-high

## Operation
- Access decode:
  - Write condition is !cs && !we && oe.
  - Read condition is !cs && we && !oe.
  - Side effects fire only on the first cycle the condition is true, using a registered previous-condition flag. A held strobe causes one action.
- Address 0, setup (R/W):
  - bit0 soft reset: write-1 pulses for one cycle and reads back 0.
  - bits5:1 clk_div.
  - bit6 send_en.
  - bit7 irq_en.
  - Other bits read 0.
- Address 2, state:
  - bit0 busy (FSM not IDLE), RO.
  - bit1 rx_valid, RO.
  - bit2 tx_full, RO.
  - bit3 tx_empty, RO.
  - bit4 rx_overrun, sticky, write-1-clear.
  - bit5 tx_overflow, sticky, write-1-clear.
- Address 4, transmit (WO): a write pushes data_in[7:0] into the TX FIFO. Push when full is dropped and sets tx_overflow. Reads return 0.
- Address 6, receive (RO): a read returns {8'h00, rx_byte} and clears rx_valid.
- Unmapped addresses: read 0, writes ignored.
- spi_clk_div = setup[5:1] continuously.
- irq = irq_en && rx_valid.
- FSM states:
  - IDLE → LOAD when send_en && !tx_empty.
  - LOAD: pop FIFO head into the spi_tx register; → START.
  - START: spi_start = 1 for this cycle only; → WAIT_BUSY.
  - WAIT_BUSY: → WAIT_DONE when spi_busy = 1, or → IDLE directly if spi_new_data pulses first.
  - WAIT_DONE: on spi_new_data, capture spi_rx into rx_byte; set rx_overrun if rx_valid was already 1; set rx_valid; → IDLE.
- Clearing send_en mid-transfer: the current byte completes, then the FSM stays in IDLE.
- Soft reset (and rst_n low):
  - FSM → IDLE; FIFO flushed; rx_valid, rx_overrun and tx_overflow cleared.
  - spi_rst high for that one cycle.
  - Setup fields are kept on soft reset and cleared by rst_n.

## Timing
- Reset values:
  - data_out=0, spi_rst=1 while rst_n low, then 0.
  - spi_clk_div=0, spi_start=0, spi_tx=0, irq=0.
  - FIFO empty; all flags 0; setup=0.
- Register write takes effect on the clock edge ending the first write cycle.
- data_out updates one cycle after the first read cycle and holds until the next read.
- TX latency:
  - Push registered at edge E (FIFO count nonzero after E).
  - LOAD entered at E+1.
  - spi_start high between E+2 and E+3 with spi_tx valid.
- Back-to-back bytes: the next spi_start comes 3 cycles after the spi_new_data pulse (IDLE, LOAD, START).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, no overflow even if full before the pop.
  - spi_new_data in the same cycle as an RX read: the new byte wins. rx_valid stays 1, rx_overrun not set, and the read returns the old byte.
  - Write-1-clear of a flag in the same cycle it is being set: the set wins.
  - Soft reset together with a TX write: reset wins and the byte is discarded.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.

## Test plan
- Reset: hold rst_n low 3 cycles, release → state reads 0x0008, data_out=0, spi_start never asserted.
- Single byte:
  - Stimulus: setup=0x004A (div=5, send_en), then TX write 0xA5; model spi answers 0x3C after 10 cycles.
  - Expected: spi_clk_div=5; spi_start one pulse 2 cycles after push with spi_tx=0xA5; state bit1=1; RX read returns 0x003C, then state bit1=0.
- FIFO full/overflow:
  - Stimulus: send_en=0, write 5 bytes 0x01..0x05.
  - Expected: state=0x0024 (full, overflow). Then set send_en: bytes 0x01..0x04 are sent in order and 0x05 never.
- Overrun and irq:
  - Stimulus: irq_en=1; two transfers, no RX read.
  - Expected: irq rises on the first spi_new_data; state bit4=1 after the second; RX read returns the second byte; writing 0x0010 to state clears bit4.
- Held strobe: a TX write held for 6 cycles pushes exactly one byte.
- Soft reset mid-transfer:
  - Stimulus: write setup bit0 while in WAIT_DONE with 2 bytes queued.
  - Expected: spi_rst pulses one cycle; FSM IDLE; state=0x0008; no further spi_start; div unchanged.
